emu_result_monitor: RTL



---
 rtl/emu_result_monitor.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/emu_result_monitor.sv
// Test-result monitor for RV32I emulation runs: snoops magic-window writes, watches the PC
// for hangs, runs a watchdog and latches one sticky verdict that is also blinked on an LED.
module emu_result_monitor #(
  parameter logic [15:0] MAGIC_HI       = 16'hDEAD,
  parameter logic [31:0] PASS_VALUE     = 32'd1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd120_000_000,
  parameter logic [31:0] HANG_CYCLES    = 32'd1_200_000,
  parameter logic [23:0] BLINK_DIV      = 24'd3_000_000,
  parameter logic [4:0]  MAX_BLINKS     = 5'd15
) (
  input  logic        clk,
  input  logic        rst,
  // Bus handshake: a write is observed only on the cycle where mem_write && mem_resp are
  // both high; a request held without mem_resp is invisible, so a multi-cycle write counts once.
  input  logic        mem_write,
  input  logic        mem_resp,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] pc,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        hung,
  output logic [30:0] fail_code,
  output logic        status_led,
  output logic [31:0] run_cycles,
  // Debug: state 0=RUN 1=PASS 2=FAIL 3=TIMEOUT 4=HUNG; blink phase 0=ON 1=OFF 2=GAP
  output logic [2:0]  state_dbg,
  output logic [1:0]  phase_dbg
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HUNG    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_ON  = 2'd0,
    PH_OFF = 2'd1,
    PH_GAP = 2'd2
  } phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [23:0] presc_q, presc_d;
  logic [4:0]  pulse_q, pulse_d;
  logic [1:0]  gap_q, gap_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] pc_prev;
  logic [31:0] run_next;
  logic [4:0]  blink_n;
  logic        magic_hit;
  logic        hang_trip;
  logic        timeout_trip;
  logic        half_done;
  logic        entering;
  logic        unused_addr_lo;

  assign unused_addr_lo = ^mem_addr[15:0];

  assign magic_hit    = mem_write && mem_resp && (mem_addr[31:16] == MAGIC_HI);
  assign run_next     = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
  assign stall_d      = (pc != pc_prev) ? 32'd0 :
                        ((stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1);
  assign hang_trip    = (HANG_CYCLES != 32'd0) && (stall_d == HANG_CYCLES);
  assign timeout_trip = (TIMEOUT_CYCLES != 32'd0) && (run_next == TIMEOUT_CYCLES);
  assign half_done    = (presc_q == BLINK_DIV - 24'd1);
  assign entering     = (state_d != state_q);

  // Pulse count shown for FAIL: code 0 still gives one pulse so the LED never looks idle.
  always_comb begin
    if (fail_code == 31'd0)
      blink_n = 5'd1;
    else if (fail_code > {26'd0, MAX_BLINKS})
      blink_n = MAX_BLINKS;
    else
      blink_n = fail_code[4:0];
  end

  // Verdict FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Verdict FSM: next state; priority is magic hit, then hang, then watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (magic_hit)
          state_d = (mem_wdata == PASS_VALUE) ? ST_PASS : ST_FAIL;
        else if (hang_trip)
          state_d = ST_HUNG;
        else if (timeout_trip)
          state_d = ST_TIMEOUT;
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HUNG: state_d = state_q;
      default: state_d = ST_RUN;
    endcase
  end

  // Verdict FSM: outputs decoded from registered state
  always_comb begin
    pass       = 1'b0;
    fail       = 1'b0;
    timeout    = 1'b0;
    hung       = 1'b0;
    status_led = 1'b0;
    state_dbg  = state_q;
    phase_dbg  = phase_q;
    case (state_q)
      ST_RUN:     status_led = pc[13];
      ST_PASS:    begin pass = 1'b1;    status_led = 1'b1;               end
      ST_FAIL:    begin fail = 1'b1;    status_led = (phase_q == PH_ON); end
      ST_TIMEOUT: begin timeout = 1'b1; status_led = (phase_q == PH_ON); end
      ST_HUNG:    begin hung = 1'b1;    status_led = (phase_q == PH_ON); end
      default:    status_led = 1'b0;
    endcase
  end

  // Blink engine next state; held cleared in RUN and on the entry edge of any verdict
  always_comb begin
    phase_d = phase_q;
    presc_d = presc_q;
    pulse_d = pulse_q;
    gap_d   = gap_q;
    if (state_q == ST_RUN || entering) begin
      phase_d = PH_ON;
      presc_d = 24'd0;
      pulse_d = 5'd0;
      gap_d   = 2'd0;
    end else if (state_q != ST_PASS) begin
      if (half_done) begin
        presc_d = 24'd0;
        case (phase_q)
          PH_ON: phase_d = PH_OFF;
          PH_OFF: begin
            if (state_q == ST_FAIL && (pulse_q + 5'd1) == blink_n) begin
              phase_d = PH_GAP;
              pulse_d = 5'd0;
            end else begin
              phase_d = PH_ON;
              if (state_q == ST_FAIL) pulse_d = pulse_q + 5'd1;
            end
          end
          PH_GAP: begin
            if (gap_q == 2'd3) begin
              phase_d = PH_ON;
              gap_d   = 2'd0;
            end else begin
              gap_d = gap_q + 2'd1;
            end
          end
          default: phase_d = PH_ON;
        endcase
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_ON;
      presc_q    <= 24'd0;
      pulse_q    <= 5'd0;
      gap_q      <= 2'd0;
      stall_q    <= 32'd0;
      pc_prev    <= 32'd0;
      run_cycles <= 32'd0;
      fail_code  <= 31'd0;
    end else begin
      phase_q <= phase_d;
      presc_q <= presc_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
      pc_prev <= pc;
      if (state_q == ST_RUN) run_cycles <= run_next;
      if (state_q == ST_RUN && state_d == ST_FAIL) fail_code <= mem_wdata[31:1];
    end
  end

endmodule
